// File: rtl/reg_bus_sequencer_pkg.sv
// Shared definitions for the register-bus sequencer: op encodings, FSM
// states and default sizing.
package reg_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_LDI = 3'd1,
    OP_LD  = 3'd2,
    OP_ST  = 3'd3,
    OP_INC = 3'd4,
    OP_DEC = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int DEFAULT_NREG    = 4;
  localparam int DEFAULT_TIMEOUT = 15;

  // Encodings 6 and 7 are reserved and rejected with an error pulse.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

  function automatic logic op_is_mem(input logic [2:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_strobe_decoder.sv
// Combinational map from sequencer state and latched command to the
// one-hot register strobes and memory-port controls.
module strobe_decoder
  import reg_bus_sequencer_pkg::*;
#(
  parameter int NREG = DEFAULT_NREG,
  localparam int SW = $clog2(NREG)
) (
  input  state_e          i_state,
  input  op_e             i_op,
  input  logic [SW-1:0]   i_src,
  input  logic [SW-1:0]   i_dst,
  input  logic            i_mem_ack,
  output logic [NREG-1:0] o_rdata,
  output logic [NREG-1:0] o_wdata,
  output logic [NREG-1:0] o_raddr,
  output logic [NREG-1:0] o_waddr,
  output logic [NREG-1:0] o_inc,
  output logic [NREG-1:0] o_dec,
  output logic            o_imm_drv_en,
  output logic            o_mem_req,
  output logic            o_mem_we
);

  logic [NREG-1:0] w_src_hot;
  logic [NREG-1:0] w_dst_hot;

  // One-hot expansion of the latched register indices.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_hot
    assign w_src_hot[gi] = (i_src == SW'(gi));
    assign w_dst_hot[gi] = (i_dst == SW'(gi));
  end

  // Address-bus writes are not used yet.
  assign o_waddr = '0;

  // Strobe selection; everything is quiet outside EXEC and MEM.
  always_comb begin
    o_rdata      = '0;
    o_wdata      = '0;
    o_raddr      = '0;
    o_inc        = '0;
    o_dec        = '0;
    o_imm_drv_en = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    case (i_state)
      ST_EXEC: begin
        case (i_op)
          OP_MOV: begin
            o_rdata = w_src_hot;
            o_wdata = w_dst_hot;
          end
          OP_LDI: begin
            o_imm_drv_en = 1'b1;
            o_wdata      = w_dst_hot;
          end
          OP_INC:  o_inc = w_dst_hot;
          OP_DEC:  o_dec = w_dst_hot;
          default: ;
        endcase
      end
      ST_MEM: begin
        o_raddr   = w_src_hot;
        o_mem_req = 1'b1;
        if (i_op == OP_ST) begin
          o_rdata  = w_dst_hot;
          o_mem_we = 1'b1;
        end else if (i_mem_ack) begin
          // Loaded byte is on the data bus only in the ack cycle.
          o_wdata = w_dst_hot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Micro-command sequencer: accepts one command at a time, steps through the
// strobe cycles and supervises memory handshakes with a timeout.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter int NREG    = DEFAULT_NREG,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int SW = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [2:0]      i_cmd_op,
  input  logic [SW-1:0]   i_cmd_src,
  input  logic [SW-1:0]   i_cmd_dst,
  input  logic [7:0]      i_cmd_imm,
  output logic [NREG-1:0] o_rdata,
  output logic [NREG-1:0] o_wdata,
  output logic [NREG-1:0] o_raddr,
  output logic [NREG-1:0] o_waddr,
  output logic [NREG-1:0] o_inc,
  output logic [NREG-1:0] o_dec,
  output logic            o_imm_drv_en,
  output logic [7:0]      o_imm_bus,
  output logic            o_mem_req,
  output logic            o_mem_we,
  input  logic            i_mem_ack,
  output logic            o_done,
  output logic            o_err
);

  // Last wait count at which an ack is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e        r_state;
  state_e        w_state_next;
  op_e           r_op;
  logic [SW-1:0] r_src;
  logic [SW-1:0] r_dst;
  logic [7:0]    r_imm;
  logic [7:0]    r_wait;
  logic [7:0]    w_wait_next;
  logic          r_err;
  logic          w_err_next;
  logic          w_accept;
  logic          w_legal;

  assign w_accept = i_cmd_valid && (r_state == ST_IDLE);
  assign w_legal  = op_is_legal(i_cmd_op);

  // State, wait counter, error pulse and command latches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MOV;
      r_src   <= '0;
      r_dst   <= '0;
      r_imm   <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      r_err   <= w_err_next;
      if (w_accept && w_legal) begin
        r_op  <= op_e'(i_cmd_op);
        r_src <= i_cmd_src;
        r_dst <= i_cmd_dst;
        r_imm <= i_cmd_imm;
      end
    end
  end

  // Next-state logic, timeout supervision and error detection.
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_err_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wait_next = '0;
        if (i_cmd_valid) begin
          if (!w_legal)                 w_err_next   = 1'b1;
          else if (op_is_mem(i_cmd_op)) w_state_next = ST_MEM;
          else                          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: w_state_next = ST_FIN;
      ST_MEM: begin
        if (i_mem_ack) begin
          // An ack on the final allowed cycle still wins over the timeout.
          w_state_next = ST_FIN;
          w_wait_next  = '0;
        end else if (r_wait == WAIT_LAST) begin
          w_state_next = ST_IDLE;
          w_err_next   = 1'b1;
          w_wait_next  = '0;
        end else begin
          w_wait_next = 8'(r_wait + 8'd1);
        end
      end
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_done      = (r_state == ST_FIN);
  assign o_err       = r_err;
  assign o_imm_bus   = r_imm;

  strobe_decoder #(.NREG(NREG)) u_strobe_decoder (
    .i_state      (r_state),
    .i_op         (r_op),
    .i_src        (r_src),
    .i_dst        (r_dst),
    .i_mem_ack    (i_mem_ack),
    .o_rdata      (o_rdata),
    .o_wdata      (o_wdata),
    .o_raddr      (o_raddr),
    .o_waddr      (o_waddr),
    .o_inc        (o_inc),
    .o_dec        (o_dec),
    .o_imm_drv_en (o_imm_drv_en),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we)
  );

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: a small register file and memory are driven
// by the DUT strobes; a per-cycle expected waveform built from each
// command's timing rules is compared against the DUT on every cycle.
module tb_reg_bus_sequencer;

  localparam int NREG = 4;
  localparam int T    = 15;
  localparam int MAXC = 1000;

  typedef struct packed {
    logic       ready;
    logic [3:0] rdata;
    logic [3:0] wdata;
    logic [3:0] raddr;
    logic [3:0] inc;
    logic [3:0] dec;
    logic       imm_drv;
    logic       req;
    logic       we;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [7:0] cmd_imm;
  logic [3:0] rdata, wdata, raddr, waddr, inc, dec;
  logic       imm_drv_en;
  logic [7:0] imm_bus;
  logic       mem_req, mem_we, mem_ack, done, err;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int free_idx = 3;
  int last_n = 0;

  exp_t       exp_q   [MAXC];
  logic [7:0] exp_imm [MAXC];

  logic [7:0] regs [NREG];
  logic [7:0] m_regs [NREG];
  logic [3:0] m_valid = 4'b0000;
  logic [7:0] m_imm = 8'h00;
  logic [7:0] data_bus, addr_bus;
  logic [7:0] st_addr = 8'h00;
  logic [7:0] st_data = 8'h00;

  reg_bus_sequencer #(.NREG(NREG), .TIMEOUT(T)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_src    (cmd_src),
    .i_cmd_dst    (cmd_dst),
    .i_cmd_imm    (cmd_imm),
    .o_rdata      (rdata),
    .o_wdata      (wdata),
    .o_raddr      (raddr),
    .o_waddr      (waddr),
    .o_inc        (inc),
    .o_dec        (dec),
    .o_imm_drv_en (imm_drv_en),
    .o_imm_bus    (imm_bus),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .i_mem_ack    (mem_ack),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared buses: memory returns (address ^ 0x5A) on loads.
  always_comb begin
    addr_bus = 8'h00;
    data_bus = 8'h00;
    for (int i = 0; i < NREG; i++) if (raddr[i]) addr_bus = regs[i];
    if (imm_drv_en) data_bus = imm_bus;
    for (int i = 0; i < NREG; i++) if (rdata[i]) data_bus = regs[i];
    if (mem_req && !mem_we) data_bus = addr_bus ^ 8'h5A;
  end

  // Register file and memory store capture.
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (wdata[i])    regs[i] <= data_bus;
      else if (inc[i]) regs[i] <= regs[i] + 8'd1;
      else if (dec[i]) regs[i] <= regs[i] - 8'd1;
    end
    if (mem_req && mem_we && mem_ack) begin
      st_addr <= addr_bus;
      st_data <= data_bus;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // Per-cycle comparison against the expected waveform plus bus invariants.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      exp_t e;
      e = exp_q[cyc];
      chk("ready",   8'(cmd_ready),  8'(e.ready));
      chk("rdata",   8'(rdata),      8'(e.rdata));
      chk("wdata",   8'(wdata),      8'(e.wdata));
      chk("raddr",   8'(raddr),      8'(e.raddr));
      chk("waddr",   8'(waddr),      8'd0);
      chk("inc",     8'(inc),        8'(e.inc));
      chk("dec",     8'(dec),        8'(e.dec));
      chk("imm_drv", 8'(imm_drv_en), 8'(e.imm_drv));
      chk("imm_bus", imm_bus,        exp_imm[cyc]);
      chk("mem_req", 8'(mem_req),    8'(e.req));
      chk("mem_we",  8'(mem_we),     8'(e.we));
      chk("done",    8'(done),       8'(e.done));
      chk("err",     8'(err),        8'(e.err));
      chk("inv_rd1",   8'($countones(rdata) <= 1), 8'd1);
      chk("inv_rdimm", 8'((|rdata) && imm_drv_en), 8'd0);
      chk("inv_ra1",   8'($countones(raddr) <= 1), 8'd1);
      chk("inv_ww",    8'(wdata & waddr),          8'd0);
      chk("inv_incdec", 8'((|inc) && (|dec)),      8'd0);
    end
  end

  task automatic check_regs();
    for (int i = 0; i < NREG; i++)
      if (m_valid[i]) chk($sformatf("reg%0d", i), regs[i], m_regs[i]);
  endtask

  task automatic wait_free();
    while (cyc < free_idx) begin
      @(posedge clk);
      #1;
    end
    check_regs();
  endtask

  // Offer one command when the sequencer is known idle; write its expected
  // waveform; drive mem_ack ack_d cycles after mem_req rises (<0: never).
  task automatic issue(input logic [2:0] op, input int src, input int dst,
                       input logic [7:0] imm, input int ack_d);
    int   n;
    exp_t e;
    logic [3:0] sh, dh;
    wait_free();
    n = cyc + 1;
    last_n = n;
    sh = 4'(1 << src);
    dh = 4'(1 << dst);
    $display("cmd cyc=%0d op=%0d src=%0d dst=%0d imm=%h ack_d=%0d", n, op, src, dst, imm, ack_d);
    if (op > 3'd5) begin
      e = idle_e();
      e.err = 1'b1;
      exp_q[n] = e;
      free_idx = n;
    end else begin
      for (int k = n; k < MAXC; k++) exp_imm[k] = imm;
      m_imm = imm;
      if (op == 3'd2 || op == 3'd3) begin
        e = '0;
        e.raddr = sh;
        e.req = 1'b1;
        if (op == 3'd3) begin
          e.we = 1'b1;
          e.rdata = dh;
        end
        if (ack_d < 0) begin
          for (int k = n; k < n + T; k++) exp_q[k] = e;
          exp_q[n+T] = idle_e();
          exp_q[n+T].err = 1'b1;
          free_idx = n + T;
        end else begin
          for (int k = n; k <= n + ack_d; k++) exp_q[k] = e;
          if (op == 3'd2) begin
            exp_q[n+ack_d].wdata = dh;
            m_regs[dst] = m_regs[src] ^ 8'h5A;
            m_valid[dst] = 1'b1;
          end
          e = '0;
          e.done = 1'b1;
          exp_q[n+ack_d+1] = e;
          free_idx = n + ack_d + 2;
        end
      end else begin
        e = '0;
        case (op)
          3'd0: begin e.rdata = sh; e.wdata = dh; m_regs[dst] = m_regs[src]; end
          3'd1: begin e.imm_drv = 1'b1; e.wdata = dh; m_regs[dst] = imm; m_valid[dst] = 1'b1; end
          3'd4: begin e.inc = dh; m_regs[dst] = m_regs[dst] + 8'd1; end
          default: begin e.dec = dh; m_regs[dst] = m_regs[dst] - 8'd1; end
        endcase
        exp_q[n] = e;
        e = '0;
        e.done = 1'b1;
        exp_q[n+1] = e;
        free_idx = n + 2;
      end
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_src = 2'(src);
    cmd_dst = 2'(dst);
    cmd_imm = imm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_imm = 8'h00;
    if (ack_d >= 0) begin
      while (cyc < n + ack_d) begin
        @(posedge clk);
        #1;
      end
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < MAXC; i++) begin
      exp_q[i] = idle_e();
      exp_imm[i] = 8'h00;
    end
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_src = 2'd0;
    cmd_dst = 2'd0;
    cmd_imm = 8'h00;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready_lit", 8'(cmd_ready), 8'd1);
    chk("rst_imm_lit", imm_bus, 8'h00);

    // Initialise the register file through immediate loads.
    issue(3'd1, 0, 0, 8'h10, -1);
    issue(3'd1, 0, 1, 8'h22, -1);
    issue(3'd1, 0, 2, 8'hFF, -1);
    issue(3'd1, 0, 3, 8'hA5, -1);
    wait_free();
    chk("r3_ldi_lit", regs[3], 8'hA5);

    issue(3'd0, 1, 2, 8'h00, -1);
    wait_free();
    chk("r2_mov_lit", regs[2], 8'h22);
    issue(3'd0, 3, 3, 8'h00, -1);
    wait_free();
    chk("r3_self_lit", regs[3], 8'hA5);

    // Load with ack after 4 cycles: 0x10 ^ 0x5A.
    issue(3'd2, 0, 1, 8'h00, 4);
    wait_free();
    chk("r1_ld_lit", regs[1], 8'h4A);

    issue(3'd3, 1, 3, 8'h00, 2);
    wait_free();
    chk("st_addr_lit", st_addr, 8'h4A);
    chk("st_data_lit", st_data, 8'hA5);

    // Store with no ack times out; nothing is written.
    issue(3'd3, 0, 2, 8'h00, -1);
    wait_free();
    chk("st_to_addr_lit", st_addr, 8'h4A);

    // Ack on the last allowed cycle still succeeds: 0x22 ^ 0x5A.
    issue(3'd2, 2, 0, 8'h00, T - 1);
    wait_free();
    chk("r0_ldlate_lit", regs[0], 8'h78);

    issue(3'd1, 0, 2, 8'hFF, -1);
    issue(3'd4, 0, 2, 8'h00, -1);
    wait_free();
    chk("r2_inc_lit", regs[2], 8'h00);
    issue(3'd5, 0, 2, 8'h00, -1);
    wait_free();
    chk("r2_dec_lit", regs[2], 8'hFF);

    issue(3'd7, 1, 2, m_imm, -1);
    issue(3'd6, 0, 3, m_imm, -1);

    // Stray ack while idle is ignored.
    wait_free();
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;

    // Reset in the middle of a memory wait.
    issue(3'd2, 0, 1, 8'h3C, -1);
    repeat (3) @(posedge clk);
    #1;
    k = cyc;
    $display("rst cyc=%0d", k + 1);
    rst = 1'b1;
    for (int i = k + 1; i <= last_n + T + 1; i++) exp_q[i] = idle_e();
    for (int i = k + 1; i < MAXC; i++) exp_imm[i] = 8'h00;
    m_imm = 8'h00;
    free_idx = k + 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mem_req_lit", 8'(mem_req), 8'd0);
    chk("rst_raddr_lit", 8'(raddr), 8'd0);

    issue(3'd0, 0, 3, 8'h00, -1);
    wait_free();
    chk("r3_after_rst_lit", regs[3], 8'h78);
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
